// File: rtl/ram_burst_pkg.sv
// Shared types for the RAM burst reader: controller states and skid buffer sizing.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_skid_buf.sv
// Two-entry FIFO holding {last, data} words captured from the RAM until the stream accepts them.
module ram_skid_buf
    import ram_burst_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [SKID_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == SKID_CNT_W'(SKID_DEPTH));

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of words from a 1-cycle-latency RAM and streams them out over valid/ready.
// Define RAM_BURST_CHECKSUM_EN to add a running modulo-2**DATA_WIDTH checksum output.
module ram_burst_reader
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef RAM_BURST_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int LW = ADDR_WIDTH + 1;

    // Stream handshake: a beat transfers on a clock edge where m_valid and m_ready are both high;
    // m_valid never drops and m_data/m_last never change while a beat waits for m_ready.

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           issue_cnt;
    logic                    in_flight;
    logic                    in_flight_last;
    logic                    issue;
    logic                    room;
    logic                    pop;
    logic                    drain_ok;
    logic                    start_acc;
    logic [DATA_WIDTH:0]     head;
    logic [SKID_CNT_W-1:0]   buf_count;
    logic                    buf_full;
    logic                    buf_empty;

    assign start_acc  = (state == IDLE) && start;
    assign pop        = m_valid && m_ready;
    assign issue_addr = base_q + issue_cnt[ADDR_WIDTH-1:0];

    // Buffered words plus the read in flight, less this cycle's pop, must leave a free slot.
    assign room = in_flight ? (buf_empty || (buf_count == SKID_CNT_W'(1) && pop))
                            : (!buf_full || pop);
    assign issue    = (state == RUN) && (issue_cnt < len_q) && room;
    assign drain_ok = !in_flight && (buf_empty || (buf_count == SKID_CNT_W'(1) && pop));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base_q         <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            issue_cnt      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            state          <= state_next;
            in_flight      <= issue;
            in_flight_last <= issue && (issue_cnt + LW'(1) == len_q);
            if (start_acc) begin
                base_q    <= base_addr;
                len_q     <= length;
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + LW'(1);
                addr_q    <= issue_addr;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (length == '0) ? DONE : RUN;
            RUN:     if (issue_cnt == len_q) state_next = DRAIN;
            DRAIN:   if (drain_ok) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    ram_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data ({in_flight_last, ram_q}),
        .pop       (pop),
        .head_data (head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // The address is presented combinationally in the issue cycle so data returns one cycle later.
    assign ram_addr = issue ? issue_addr : addr_q;
    assign ram_we   = 1'b0;
    assign ram_data = '0;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign m_valid  = !buf_empty;
    assign m_data   = head[DATA_WIDTH-1:0];
    assign m_last   = head[DATA_WIDTH];

`ifdef RAM_BURST_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + m_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model, randomized bursts and backpressure, queue-based reference.
module tb_ram_burst_reader;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b1;
`ifdef RAM_BURST_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem [256];
  logic [DW:0]   exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            beats = 0;
  int            first_valid_cyc = 0;
  bit            seen_valid = 0;
  bit            rand_ready = 0;
  bit            stall_prev = 0;
  logic [DW:0]   prev_beat = '0;

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_data  (ram_data),
    .ram_q     (ram_q),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
`ifdef RAM_BURST_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // clock / cycle counter / RAM model / ready driver
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    ram_q <= mem[ram_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // scoreboard: every accepted beat must match the head of exp_q; stalled beats must hold
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (done) done_cnt++;
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (stall_prev) begin
        check_eq("stall_valid", 32'(m_valid), 32'd1);
        check_eq("stall_beat", 32'({m_last, m_data}), 32'(prev_beat));
      end
      if (m_valid && m_ready) begin
        check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_eq("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
          beats++;
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_beat = {m_last, m_data};
    end
  end

  // reference: word i of a burst is mem[(base+i) mod 256], last on i == len-1
  task automatic load_expect(input int b, input int len, output logic [DW-1:0] sum);
    logic [DW-1:0] d;
    logic          l;
    exp_q.delete();
    sum = '0;
    for (int i = 0; i < len; i++) begin
      d = mem[(b + i) % 256];
      l = (i == len - 1);
      exp_q.push_back({l, d});
      sum = sum + d;
    end
  endtask

  task automatic issue_start(input int b, input int len, output int start_cyc);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW + 1)'(len);
    done_cnt = 0;
    seen_valid = 0;
    beats = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    length = (AW + 1)'($urandom);
    start_cyc = cyc;
`ifdef RAM_BURST_CHECKSUM_EN
    check_eq("checksum_clear", 32'(checksum), 32'd0);
`endif
  endtask

  task automatic run_burst(input int b, input int len);
    logic [DW-1:0] sum;
    int            start_cyc;
    int            done_cyc;
    int            waited;
    bit            got_done;
    load_expect(b, len, sum);
    issue_start(b, len, start_cyc);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    got_done = 0;
    waited = 0;
    done_cyc = 0;
    while (!got_done && waited < len * 8 + 40) begin
      @(negedge clk);
      waited++;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        check_eq("busy_at_done", 32'(busy), 32'd0);
      end
    end
    check_eq("done_seen", 32'(got_done), 32'd1);
    check_eq("beats_left", 32'(exp_q.size()), 32'd0);
    check_eq("beat_count", 32'(beats), 32'(len));
    if (!rand_ready && got_done) begin
      check_eq("done_latency", 32'(done_cyc - start_cyc), 32'(len + 2));
      check_eq("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
    end
    @(negedge clk);
    check_eq("done_single", 32'(done), 32'd0);
    check_eq("done_count", 32'(done_cnt), 32'd1);
`ifdef RAM_BURST_CHECKSUM_EN
    check_eq("checksum", 32'(checksum), 32'(sum));
`endif
  endtask

  task automatic run_zero();
    logic [DW-1:0] sum;
    int            start_cyc;
    int            waited;
    bit            got_done;
    load_expect(0, 0, sum);
    issue_start(int'($urandom_range(0, 255)), 0, start_cyc);
    got_done = 0;
    waited = 0;
    while (!got_done && waited < 4) begin
      @(negedge clk);
      waited++;
      if (done) begin
        got_done = 1;
        check_eq("zero_busy_at_done", 32'(busy), 32'd0);
      end
    end
    check_eq("zero_done_seen", 32'(got_done), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("zero_no_valid", 32'(seen_valid), 32'd0);
    check_eq("zero_done_count", 32'(done_cnt), 32'd1);
    check_eq("zero_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_abort(input int b);
    logic [DW-1:0] sum;
    int            start_cyc;
    int            waited;
    rand_ready = 0;
    load_expect(b, 16, sum);
    issue_start(b, 16, start_cyc);
    waited = 0;
    while (beats < 3 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_eq("abort_three_beats", 32'(beats >= 3), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("abort_m_valid", 32'(m_valid), 32'd0);
    check_eq("abort_m_last", 32'(m_last), 32'd0);
    check_eq("abort_m_data", 32'(m_data), 32'd0);
`ifdef RAM_BURST_CHECKSUM_EN
    check_eq("abort_checksum", 32'(checksum), 32'd0);
`endif
    reset = 1'b0;
    done_cnt = 0;
    repeat (5) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_quiet", 32'(m_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_data", 32'(ram_data), 32'd0);
    reset = 1'b0;

    rand_ready = 0;
    run_burst(8'h10, 4);
`ifdef RAM_BURST_CHECKSUM_EN
    check_eq("checksum_identity", 32'(checksum), 32'h46);
`endif
    run_burst(8'hFE, 4);
    rand_ready = 1;
    run_burst(8'h20, 8);
    rand_ready = 0;
    run_zero();
    run_abort(8'h40);
    run_burst(0, 2);
    run_burst(8'h80, 256);

    for (int n = 0; n < 20; n++) begin
      rand_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      run_burst(int'($urandom_range(0, 255)), int'($urandom_range(1, 12)));
    end
    rand_ready = 0;
    run_burst(8'hFF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
